instr_fetch_seq: RTL

Instruction fetch sequencer that feeds the simple processor from a synchronous instruction ROM. It holds a program counter and reads one 16-bit instruction per step. It issues each instruction by raising `Run` and waits for the processor's `Done`. It then advances the PC, stops on a halt opcode, and reports an error if `Done` does not arrive within a bounded number of cycles. It sits between the ROM and the control unit and is the only driver of the processor's `instruction` and `Run` inputs.

---
 rtl/processor_pkg.sv | 34 +++
 rtl/instr_fetch_seq_if.sv | 26 ++
 rtl/exec_watchdog.sv | 33 +++
 rtl/instr_fetch_seq.sv | 111 +++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared definitions for the simple processor: opcodes, instruction field
// positions and the fetch sequencer state encoding.
package processor_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVT  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int unsigned OPC_HI   = 15;
    localparam int unsigned OPC_LO   = 13;
    localparam int unsigned IMM_FLAG = 12;
    localparam int unsigned RX_HI    = 11;
    localparam int unsigned RX_LO    = 9;
    localparam int unsigned IMM_HI   = 8;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned RY_HI    = 2;
    localparam int unsigned RY_LO    = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StExec,
        StHalt,
        StErr
    } seq_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[OPC_HI:OPC_LO] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// ROM read port and processor issue handshake seen by the fetch sequencer.
interface instr_fetch_seq_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [15:0]       instruction;
    logic              Run;
    logic              Done;

    modport master (
        output rom_addr,
        output instruction,
        output Run,
        input  rom_data,
        input  Done
    );

    modport slave (
        input  rom_addr,
        input  instruction,
        input  Run,
        output rom_data,
        output Done
    );
endinterface

// File: rtl/exec_watchdog.sv
// Cycle counter bounding how long an issued instruction may wait for Done.
module exec_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic Rest,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Never runs past Last: the sequencer leaves EXEC on Done or on expiry.
    always_comb begin
        cnt_d = '0;
        if (enable && !clear) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge Rest) begin
        if (!Rest) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == Last);
endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: reads the ROM at pc, issues each instruction
// with Run, waits for Done under a watchdog, and stops on halt or stop request.
module instr_fetch_seq
    import processor_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              Rest,
    input  logic              start,
    input  logic              stop,
    instr_fetch_seq_if.master bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              stop_pending_q, stop_pending_d;
    logic              wd_clear;
    logic              wd_expired;

    // Outputs decode straight from state so Run drops with an async reset.
    assign busy            = (state_q == StFetch) || (state_q == StLoad) || (state_q == StExec);
    assign halted          = (state_q == StHalt);
    assign err             = (state_q == StErr);
    assign pc              = pc_q;
    assign bus.rom_addr    = pc_q;
    assign bus.instruction = instr_q;
    assign bus.Run         = (state_q == StExec);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        wd_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                instr_d = bus.rom_data;
                if (is_halt(bus.rom_data)) begin
                    state_d = StHalt;
                end else begin
                    state_d  = StExec;
                    wd_clear = 1'b1;
                end
            end
            StExec: begin
                // Done wins over a simultaneous expiry.
                if (bus.Done) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = (stop_pending_q || stop) ? StIdle : StFetch;
                end else if (wd_expired) begin
                    state_d = StErr;
                end
            end
            StHalt, StErr: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        stop_pending_d = stop_pending_q;
        if (state_d == StIdle) begin
            stop_pending_d = 1'b0;
        end else if (busy && stop) begin
            stop_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge Rest) begin
        if (!Rest) begin
            state_q        <= StIdle;
            pc_q           <= '0;
            instr_q        <= 16'h0000;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .Rest    (Rest),
        .clear   (wd_clear),
        .enable  (state_q == StExec),
        .expired (wd_expired)
    );
endmodule
